pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multi-cycle fetch/execute controller for the program counter datapath.
- Drives the 2-bit PC select (PS) and the 64-bit PC "in" operand.
- Decodes LEGv8 branch instructions from ROM output and resolves conditional branches against a latched NZCV status register.
- Keeps retired-instruction and taken-branch counters; sits between instruction ROM, register file, ALU flags and the PC block.

Parameters:
- FETCH_WAIT, 1, ROM read latency in cycles spent in FETCH (legal range 1-15).
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  ROM output for the current PC.
- stall  input  1  freeze request from downstream.
- flags_in  input  4  {N,Z,C,V} from the ALU.
- set_flags  input  1  latch flags_in (honoured in EXECUTE only).
- reg_zero  input  1  register-file read of Rt equals zero (for CBZ/CBNZ).
- reg_value  input  64  register-file read of Rn (for BR).
- PS  output  2  PC mux select: 00 hold, 01 PC+4, 10 load target, 11 PC+4+(target<<2).
- target  output  64  PC "in" operand.
- instr_valid  output  1  high in EXECUTE; the datapath commits this cycle.
- link_write  output  1  high in EXECUTE for BL (X30 <= PC+4).
- halted  output  1  high in HALT state.
- retired_count  output  CNT_WIDTH  instructions executed.
- taken_count  output  CNT_WIDTH  branches taken.

Behaviour:
- States: INIT, FETCH, EXECUTE, HALT. The state register is updated on the clock edge; all outputs other than the counters are combinational from state and latched data.
- Reset (reset=1 at an edge):
  - state <= INIT; flags <= 0; counters <= 0; wait counter <= 0.
  - Reset aborts any state, including mid-FETCH or HALT.
- INIT (one cycle): PS=10, target=0, so the PC loads 0. Next state is FETCH.
- FETCH:
  - PS=00; instr_valid=0.
  - The wait counter runs 0..FETCH_WAIT-1.
  - On the last count, instr is latched into the IR and state goes to EXECUTE.
- EXECUTE (one cycle): instr_valid=1. Decode uses the IR:
  - B (IR[31:26]=000101): PS=11, target=sext(imm26)-1, taken.
  - BL (100101): same as B, plus link_write=1.
  - CBZ (IR[31:24]=10110100): taken if reg_zero. CBNZ (10110101): taken if !reg_zero. For both, target=sext(IR[23:5])-1.
  - B.cond (IR[31:24]=01010100): taken if cond(IR[3:0]), evaluated on the latched flags, not on flags_in. target=sext(IR[23:5])-1.
  - Why the -1: the datapath adds the offset to PC+4, so subtracting one word gives architectural PC+imm*4.
  - Conditional branch taken: PS=11. Not taken: PS=01.
  - BR (IR[31:21]=11010110000): PS=10, target=reg_value, taken.
  - HLT (IR[31:21]=11010100010): PS=00; next state is HALT; retired_count still increments.
  - Any other instruction: PS=01, target=0.
  - Next state is FETCH, except after HLT.
  - retired_count increments by 1; taken_count increments by 1 if taken.
  - If set_flags=1, flags <= flags_in at the end of the cycle. A B.cond in the same cycle uses the old flags.
- Condition codes:
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !(C&!Z); 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE !(GT); 14 and 15 AL.
- HALT: PS=00, halted=1. Stays in HALT until reset; stall has no effect.
- stall=1 (any state except INIT and HALT):
  - State, wait counter, IR, flags and counters hold.
  - PS is forced to 00; instr_valid=0; link_write=0.
  - The instruction resumes unchanged when stall drops.
  - INIT ignores stall.
- Counters wrap modulo 2^CNT_WIDTH with no saturation.
- sext widths: imm26 and imm19 are sign-extended to 64 bits before the -1, and arithmetic is 64-bit two's complement.

Test Plan:
- Reset release, FETCH_WAIT=1:
  - Cycle 0 (INIT): PS=10, target=0.
  - Cycle 1 (FETCH): PS=00.
  - Cycle 2: EXECUTE.
  - Sequence repeats every 2 cycles.
- ADD (0x8B020020), then B imm26=+3:
  - ADD executes with PS=01, retired_count=1.
  - B executes with PS=11, target=2, taken_count=1.
  - B imm26=-1: target=0xFFFF_FFFF_FFFF_FFFE.
- Flag conditions:
  - SUBS with set_flags=1, flags_in=0100 (Z), followed by B.EQ: PS=11.
  - With flags_in=0000: PS=01.
  - B.cond with set_flags=1 in the same cycle uses the previous flags.
- CBZ/CBNZ/BR:
  - CBZ with reg_zero=1: PS=11. CBNZ with reg_zero=1: PS=01.
  - BR with reg_value=0x1000: PS=10, target=0x1000.
  - BL: link_write=1 for exactly 1 cycle.
- Stall:
  - stall=1 for 3 cycles during EXECUTE of B: PS=00 and counters frozen for those cycles.
  - When stall drops: PS=11, taken_count increments once.
- HLT, then reset:
  - HLT: halted=1 and PS=00 for 10+ cycles; retired_count incremented once.
  - reset=1 mid-FETCH with FETCH_WAIT=4: next cycle is INIT, counters=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute controller for the PC datapath: fetches from ROM,
// decodes LEGv8 branches, resolves conditions on latched NZCV, counts retirements.
module pc_sequencer #(
   parameter int unsigned FETCH_WAIT = 1,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [31:0]          instr,
   input  logic                 stall,
   input  logic [3:0]           flags_in,
   input  logic                 set_flags,
   input  logic                 reg_zero,
   input  logic [63:0]          reg_value,
   output logic [1:0]           PS,
   output logic [63:0]          target,
   output logic                 instr_valid,
   output logic                 link_write,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] retired_count,
   output logic [CNT_WIDTH-1:0] taken_count
);

   localparam int unsigned       WAIT_W    = 4;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_WAIT - 1);

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_LOAD = 2'b10;
   localparam logic [1:0] PS_REL  = 2'b11;

   typedef enum logic [1:0] {ST_INIT, ST_FETCH, ST_EXEC, ST_HALT} state_t;
   typedef enum logic [2:0] {OP_OTHER, OP_B, OP_BL, OP_CBZ, OP_CBNZ,
                             OP_BCOND, OP_BR, OP_HLT} op_t;

   state_t                state_q, state_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [31:0]           ir_q, ir_d;
   logic [3:0]            flags_q, flags_d;
   logic [CNT_WIDTH-1:0]  retired_q, retired_d;
   logic [CNT_WIDTH-1:0]  taken_q, taken_d;

   op_t         op;
   logic [63:0] imm26_tgt;
   logic [63:0] imm19_tgt;
   logic [1:0]  exec_ps;
   logic [63:0] exec_target;
   logic        exec_taken;
   logic        exec_link;
   logic        exec_halt;

   // Condition evaluation on {N,Z,C,V}; odd codes invert the even base test except AL.
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, res;
      n = nzcv[3];
      z = nzcv[2];
      c = nzcv[1];
      v = nzcv[0];
      case (cond[3:1])
         3'd0:    res = z;
         3'd1:    res = c;
         3'd2:    res = n;
         3'd3:    res = v;
         3'd4:    res = c & ~z;
         3'd5:    res = (n == v);
         3'd6:    res = ~z & (n == v);
         default: res = 1'b1;
      endcase
      return (cond[0] && (cond != 4'hF)) ? ~res : res;
   endfunction

   // Opcode classification of the latched instruction.
   always_comb begin
      op = OP_OTHER;
      if (ir_q[31:26] == 6'b000101)
         op = OP_B;
      else if (ir_q[31:26] == 6'b100101)
         op = OP_BL;
      else if (ir_q[31:24] == 8'hB4)
         op = OP_CBZ;
      else if (ir_q[31:24] == 8'hB5)
         op = OP_CBNZ;
      else if (ir_q[31:24] == 8'h54)
         op = OP_BCOND;
      else if (ir_q[31:21] == 11'b11010110000)
         op = OP_BR;
      else if (ir_q[31:21] == 11'b11010100010)
         op = OP_HLT;
   end

   // The datapath adds the offset to PC+4, so one word is taken off the immediate.
   assign imm26_tgt = {{38{ir_q[25]}}, ir_q[25:0]} - 64'd1;
   assign imm19_tgt = {{45{ir_q[23]}}, ir_q[23:5]} - 64'd1;

   // Execute-cycle PC control for the decoded instruction.
   always_comb begin
      exec_ps     = PS_INC;
      exec_target = '0;
      exec_taken  = 1'b0;
      exec_link   = 1'b0;
      exec_halt   = 1'b0;
      case (op)
         OP_B, OP_BL: begin
            exec_ps     = PS_REL;
            exec_target = imm26_tgt;
            exec_taken  = 1'b1;
            exec_link   = (op == OP_BL);
         end
         OP_CBZ, OP_CBNZ, OP_BCOND: begin
            exec_target = imm19_tgt;
            if (op == OP_CBZ)
               exec_taken = reg_zero;
            else if (op == OP_CBNZ)
               exec_taken = ~reg_zero;
            else
               exec_taken = cond_pass(ir_q[3:0], flags_q);
            exec_ps = exec_taken ? PS_REL : PS_INC;
         end
         OP_BR: begin
            exec_ps     = PS_LOAD;
            exec_target = reg_value;
            exec_taken  = 1'b1;
         end
         OP_HLT: begin
            exec_ps   = PS_HOLD;
            exec_halt = 1'b1;
         end
         default: begin
            exec_ps     = PS_INC;
            exec_target = '0;
         end
      endcase
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      ir_d        = ir_q;
      flags_d     = flags_q;
      retired_d   = retired_q;
      taken_d     = taken_q;
      PS          = PS_HOLD;
      target      = '0;
      instr_valid = 1'b0;
      link_write  = 1'b0;
      halted      = 1'b0;

      case (state_q)
         ST_INIT: begin
            PS      = PS_LOAD;
            target  = '0;
            wait_d  = '0;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (!stall) begin
               if (wait_q == WAIT_LAST) begin
                  ir_d    = instr;
                  wait_d  = '0;
                  state_d = ST_EXEC;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
         end
         ST_EXEC: begin
            target = exec_target;
            if (!stall) begin
               PS          = exec_ps;
               instr_valid = 1'b1;
               link_write  = exec_link;
               retired_d   = retired_q + CNT_WIDTH'(1);
               if (exec_taken)
                  taken_d = taken_q + CNT_WIDTH'(1);
               if (set_flags)
                  flags_d = flags_in;
               state_d = exec_halt ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_INIT;
         wait_q    <= '0;
         ir_q      <= '0;
         flags_q   <= '0;
         retired_q <= '0;
         taken_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         ir_q      <= ir_d;
         flags_q   <= flags_d;
         retired_q <= retired_d;
         taken_q   <= taken_d;
      end
   end

   assign retired_count = retired_q;
   assign taken_count   = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a transaction-level model.
module tb_pc_sequencer;

   localparam int unsigned CW = 32;

   localparam logic [31:0] W_ADD   = 32'h8B020020;
   localparam logic [31:0] W_SUBS  = 32'hEB020020;
   localparam logic [31:0] W_HLT   = 32'hD4400000;
   localparam logic [31:0] W_BR    = 32'hD61F0000;

   logic        clock = 1'b0;
   logic        reset, reset4, stall, set_flags, reg_zero;
   logic [31:0] instr;
   logic [3:0]  flags_in;
   logic [63:0] reg_value;

   logic [1:0]    ps, ps4;
   logic [63:0]   tgt, tgt4;
   logic          valid, valid4, link, link4, halted, halted4;
   logic [CW-1:0] ret, ret4, tkn, tkn4;

   always #5 clock = ~clock;

   pc_sequencer #(.FETCH_WAIT(1), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .instr(instr), .stall(stall),
      .flags_in(flags_in), .set_flags(set_flags), .reg_zero(reg_zero),
      .reg_value(reg_value), .PS(ps), .target(tgt), .instr_valid(valid),
      .link_write(link), .halted(halted), .retired_count(ret), .taken_count(tkn)
   );

   pc_sequencer #(.FETCH_WAIT(4), .CNT_WIDTH(CW)) dut4 (
      .clock(clock), .reset(reset4), .instr(instr), .stall(stall),
      .flags_in(flags_in), .set_flags(set_flags), .reg_zero(reg_zero),
      .reg_value(reg_value), .PS(ps4), .target(tgt4), .instr_valid(valid4),
      .link_write(link4), .halted(halted4), .retired_count(ret4), .taken_count(tkn4)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0]  m_flags;
   int unsigned m_ret, m_tkn;

   typedef struct {
      logic [1:0]  ps;
      logic [63:0] tgt;
      bit          taken;
      bit          link;
      bit          halt;
      bit          chk_tgt;
   } exp_t;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
      if (v[bits-1])
         return v - (64'd1 << bits);
      return v;
   endfunction

   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !(cy && !z);
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return !(!z && (n == v));
         default: return 1'b1;
      endcase
   endfunction

   function automatic exp_t predict(input logic [31:0] w, input logic [3:0] f,
                                    input bit rz, input logic [63:0] rv);
      exp_t e;
      e.ps = 2'b01; e.tgt = 64'd0; e.taken = 0; e.link = 0; e.halt = 0; e.chk_tgt = 1;
      if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) begin
         e.ps    = 2'b11;
         e.tgt   = sx(64'(w[25:0]), 26) - 64'd1;
         e.taken = 1;
         e.link  = w[31];
      end else if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5 || w[31:24] == 8'h54) begin
         e.tgt = sx(64'(w[23:5]), 19) - 64'd1;
         if (w[31:24] == 8'hB4)      e.taken = rz;
         else if (w[31:24] == 8'hB5) e.taken = !rz;
         else                        e.taken = cond_ok(w[3:0], f);
         e.ps = e.taken ? 2'b11 : 2'b01;
      end else if (w[31:21] == 11'b11010110000) begin
         e.ps = 2'b10; e.tgt = rv; e.taken = 1;
      end else if (w[31:21] == 11'b11010100010) begin
         e.ps = 2'b00; e.halt = 1; e.chk_tgt = 0;
      end
      return e;
   endfunction

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; set_flags = 1'b0; instr = W_ADD;
      @(posedge clock); #1;
      @(negedge clock);
      check_eq("rst_ps", 64'(ps), 64'd2);
      @(posedge clock); #1;
      reset = 1'b0;
      stall = 1'($urandom);
      m_flags = 4'd0; m_ret = 0; m_tkn = 0;
      @(negedge clock);
      check_eq("init_ps", 64'(ps), 64'd2);
      check_eq("init_tgt", tgt, 64'd0);
      check_eq("init_valid", 64'(valid), 64'd0);
      check_eq("init_ret", 64'(ret), 64'd0);
      check_eq("init_tkn", 64'(tkn), 64'd0);
      check_eq("init_halt", 64'(halted), 64'd0);
      @(posedge clock); #1;
   endtask

   task automatic fetch_phase(input logic [31:0] w, input bit rnd_stall);
      int done = 0;
      int guard = 0;
      instr = w;
      while (done < 1 && guard < 200) begin
         guard++;
         stall     = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
         set_flags = 1'($urandom);
         flags_in  = 4'($urandom);
         @(negedge clock);
         check_eq("fetch_ps", 64'(ps), 64'd0);
         check_eq("fetch_valid", 64'(valid), 64'd0);
         check_eq("fetch_link", 64'(link), 64'd0);
         check_eq("fetch_ret", 64'(ret), 64'(m_ret));
         check_eq("fetch_tkn", 64'(tkn), 64'(m_tkn));
         if (!stall) done++;
         @(posedge clock); #1;
      end
   endtask

   task automatic exec_phase(input logic [31:0] w, input int n_stall, input bit sf,
                             input logic [3:0] fin, input bit rz, input logic [63:0] rv);
      exp_t e;
      reg_zero = rz; reg_value = rv;
      for (int i = 0; i < n_stall; i++) begin
         stall = 1'b1; set_flags = 1'b1; flags_in = 4'($urandom);
         @(negedge clock);
         check_eq("stall_ps", 64'(ps), 64'd0);
         check_eq("stall_valid", 64'(valid), 64'd0);
         check_eq("stall_link", 64'(link), 64'd0);
         check_eq("stall_ret", 64'(ret), 64'(m_ret));
         check_eq("stall_tkn", 64'(tkn), 64'(m_tkn));
         @(posedge clock); #1;
      end
      stall = 1'b0; set_flags = sf; flags_in = fin;
      e = predict(w, m_flags, rz, rv);
      @(negedge clock);
      check_eq("exec_ps", 64'(ps), 64'(e.ps));
      check_eq("exec_valid", 64'(valid), 64'd1);
      check_eq("exec_link", 64'(link), 64'(e.link));
      if (e.chk_tgt) check_eq("exec_tgt", tgt, e.tgt);
      check_eq("exec_ret", 64'(ret), 64'(m_ret));
      check_eq("exec_halt", 64'(halted), 64'd0);
      @(posedge clock); #1;
      m_ret++;
      if (e.taken) m_tkn++;
      if (sf) m_flags = fin;
      set_flags = 1'b0;
   endtask

   task automatic run_instr(input logic [31:0] w, input int n_stall, input bit sf,
                            input logic [3:0] fin, input bit rz, input logic [63:0] rv);
      fetch_phase(w, 1'b0);
      exec_phase(w, n_stall, sf, fin, rz, rv);
   endtask

   function automatic logic [31:0] rand_instr();
      case ($urandom_range(0, 6))
         0:       return {8'h8B, 24'($urandom)};
         1:       return {6'b000101, 26'($urandom)};
         2:       return {6'b100101, 26'($urandom)};
         3:       return {8'hB4, 24'($urandom)};
         4:       return {8'hB5, 24'($urandom)};
         5:       return {8'h54, 24'($urandom)};
         default: return {11'b11010110000, 21'($urandom)};
      endcase
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      int          ns;
      reset = 1'b1; reset4 = 1'b1; stall = 1'b0; set_flags = 1'b0; reg_zero = 1'b0;
      instr = W_ADD; flags_in = 4'd0; reg_value = 64'd0;

      // Long ROM latency: fetch length and reset aborting a fetch.
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset4 = 1'b0;
      @(negedge clock);
      check_eq("w4_init_ps", 64'(ps4), 64'd2);
      check_eq("w4_init_tgt", tgt4, 64'd0);
      @(posedge clock); #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check_eq("w4_fetch_ps", 64'(ps4), 64'd0);
         check_eq("w4_fetch_valid", 64'(valid4), 64'd0);
         @(posedge clock); #1;
      end
      @(negedge clock);
      check_eq("w4_exec_valid", 64'(valid4), 64'd1);
      check_eq("w4_exec_ps", 64'(ps4), 64'd1);
      @(posedge clock); #1;
      @(negedge clock);
      check_eq("w4_ret", 64'(ret4), 64'd1);
      @(posedge clock); #1;
      reset4 = 1'b1;
      @(negedge clock);
      check_eq("w4_midfetch_ps", 64'(ps4), 64'd0);
      @(posedge clock); #1;
      reset4 = 1'b0;
      @(negedge clock);
      check_eq("w4_reinit_ps", 64'(ps4), 64'd2);
      check_eq("w4_reinit_ret", 64'(ret4), 64'd0);
      check_eq("w4_reinit_tkn", 64'(tkn4), 64'd0);
      @(posedge clock); #1;
      reset4 = 1'b1;

      // Directed sequence.
      do_reset();
      run_instr(W_ADD, 0, 0, 4'd0, 0, 64'd0);
      run_instr(32'h14000003, 0, 0, 4'd0, 0, 64'd0);
      run_instr(32'h17FFFFFF, 0, 0, 4'd0, 0, 64'd0);
      run_instr(W_SUBS, 0, 1, 4'b0100, 0, 64'd0);
      run_instr(32'h54000040, 0, 0, 4'd0, 0, 64'd0);
      run_instr(W_SUBS, 0, 1, 4'b0000, 0, 64'd0);
      run_instr(32'h54000040, 0, 0, 4'd0, 0, 64'd0);
      run_instr(32'h54000040, 0, 1, 4'b0100, 0, 64'd0);
      run_instr(32'h54000040, 0, 0, 4'd0, 0, 64'd0);
      run_instr(32'hB4000040, 0, 0, 4'd0, 1, 64'd0);
      run_instr(32'hB5000040, 0, 0, 4'd0, 1, 64'd0);
      run_instr(W_BR, 0, 0, 4'd0, 0, 64'h1000);
      run_instr(32'h94000005, 0, 0, 4'd0, 0, 64'd0);
      run_instr(32'h14000003, 3, 0, 4'd0, 0, 64'd0);

      // Random instruction stream with random stalls.
      for (int k = 0; k < 250; k++) begin
         w  = rand_instr();
         ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         fetch_phase(w, 1'b1);
         exec_phase(w, ns, 1'($urandom), 4'($urandom), 1'($urandom),
                    {$urandom, $urandom});
      end

      // Halt, then recover through reset.
      run_instr(W_HLT, 1, 0, 4'd0, 0, 64'd0);
      for (int i = 0; i < 12; i++) begin
         stall = 1'($urandom); instr = rand_instr(); set_flags = 1'($urandom);
         @(negedge clock);
         check_eq("halt_flag", 64'(halted), 64'd1);
         check_eq("halt_ps", 64'(ps), 64'd0);
         check_eq("halt_valid", 64'(valid), 64'd0);
         check_eq("halt_ret", 64'(ret), 64'(m_ret));
         check_eq("halt_tkn", 64'(tkn), 64'(m_tkn));
         @(posedge clock); #1;
      end
      do_reset();
      for (int k = 0; k < 20; k++) begin
         w = rand_instr();
         fetch_phase(w, 1'b1);
         exec_phase(w, 0, 1'($urandom), 4'($urandom), 1'($urandom), {$urandom, $urandom});
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
